tree_plru_ctrl: RTL
===================

Name: tree_plru_ctrl

Overview:
Parametrised, clocked tree pseudo-LRU replacement controller, successor to the fixed 8-way, 128-set tree-LRU buffer. It holds one (WAYS-1)-bit PLRU tree per cache set. It serves hit-update, miss-allocate, invalidate and set-clear requests over a valid/ready request channel, and returns the selected way over a one-deep registered valid/ready response channel. It sits between the tag-compare stage and the fill/evict logic of the cache.

Parameters:
WAYS, 8, associativity; power of two, >= 2
SETS, 128, number of sets; power of two, >= 2
WAY_W (local), clog2(WAYS), way index width
SET_W (local), clog2(SETS), set address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request ready
i_req_op  in  2  00 hit, 01 miss/allocate, 10 invalidate, 11 clear set
i_set_addr  in  SET_W  target set
i_hit_way  in  WAYS  one-hot way, used by hit and invalidate
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accepted
o_rsp_way  out  WAY_W  hit way (hit, invalidate) or victim (miss); 0 for clear and on error
o_rsp_set  out  SET_W  set of the response
o_rsp_op  out  2  op of the response
o_rsp_err  out  1  i_hit_way not one-hot on a hit or invalidate

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Tree layout: node n has children 2n+1 and 2n+2. Way w is leaf (WAYS-1)+w. Node bit 0 means the victim lies in the left (lower-way) subtree; bit 1 means the right subtree.
- Storage: SETS x (WAYS-1) flop array. Read combinationally at the addressed set; written at acceptance.
- Reset: all tree bits 0 (victim = way 0). o_rsp_valid=0, o_rsp_way=0, o_rsp_set=0, o_rsp_op=0, o_rsp_err=0. A reset during a pending response drops that response.
- o_req_ready = !o_rsp_valid || i_rsp_ready. A request is accepted when i_req_valid && o_req_ready.
- At acceptance in cycle T, the set tree updates at the clock edge ending T, and the response registers load at that same edge. o_rsp_valid is 1 in T+1, giving latency 1.
- Hit: each node on the path to the hit way is set to point away from it. o_rsp_way = encoded hit way.
- Miss: the victim is found by walking the current bits from the root. The path is then updated as an access to that victim. o_rsp_way = victim.
- Invalidate: each node on the path is set to point toward the way, so it becomes the next victim. o_rsp_way = encoded way.
- Clear: all bits of the set are cleared to 0.
- Error: on a hit or invalidate where i_hit_way has zero bits or more than one bit set, the tree is left unchanged and o_rsp_err=1.
- Back-to-back requests to the same set: the second request sees the state already written by the first. No bubble and no forwarding path are needed.
- Backpressure: while o_rsp_valid && !i_rsp_ready, all response outputs hold stable and no request is accepted. A response is replaced in the same cycle it is consumed if a new request is accepted.
- Other sets are never modified by a request.

Test Plan:
- WAYS=8. After reset, 9 misses to set 5 -> o_rsp_way 0,4,2,6,1,5,3,7,0, one per cycle with i_rsp_ready=1.
- After reset: hit way 0 (8'h01) on set 3, then miss on set 3 -> o_rsp_way=0, then o_rsp_way=4.
- After reset: invalidate 8'h20 on set 3, then miss on set 3 -> victim 5. Then clear set 3, then miss -> victim 0.
- Set isolation after reset: 3 misses to set 1 (0,4,2), then a miss to set 2 -> 0.
- Hold i_rsp_ready=0 after one miss. o_rsp_valid=1, o_rsp_way=0 stable and o_req_ready=0 for 5 cycles. The next request is not taken. Release -> the next miss returns 4.
- Hit with 8'h03 -> o_rsp_err=1, o_rsp_way=0, tree unchanged; the next miss returns 0. Asserting rst mid-stream clears o_rsp_valid, and the next miss returns 0.

Source files
------------

// File: rtl/tree_plru_ctrl.sv
// Tree pseudo-LRU replacement controller: one (WAYS-1)-bit tree per set,
// valid/ready request channel, one-deep registered response.
module tree_plru_ctrl #(
    parameter int WAYS = 8,
    parameter int SETS = 128,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [SET_W-1:0] i_set_addr,
    input  logic [WAYS-1:0]  i_hit_way,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WAY_W-1:0] o_rsp_way,
    output logic [SET_W-1:0] o_rsp_set,
    output logic [1:0]       o_rsp_op,
    output logic             o_rsp_err
);

    localparam int NODES = WAYS - 1;

    typedef enum logic [1:0] {
        OP_HIT  = 2'b00,
        OP_MISS = 2'b01,
        OP_INV  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    logic [NODES-1:0] tree [SETS];
    logic [NODES-1:0] cur_bits;
    logic [NODES-1:0] nxt_bits;
    logic [WAY_W-1:0] hit_enc;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] way_d;
    logic             err_d;
    logic             hit_onehot;
    logic             accept;

    // Rewrites the root-to-leaf path of a way: toward=1 makes it the next
    // victim, toward=0 points every node on the path away from it.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                               input logic [WAY_W-1:0] way,
                                               input logic toward);
        logic [NODES-1:0] r;
        int node;
        r = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[node[WAY_W-1:0]] = toward ? way[WAY_W-1-l] : ~way[WAY_W-1-l];
            node = 2 * node + 1 + int'(way[WAY_W-1-l]);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] find_victim(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] v;
        int node;
        v = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = bits[node[WAY_W-1:0]];
            node = 2 * node + 1 + int'(v[WAY_W-1-l]);
        end
        return v;
    endfunction

    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    assign accept      = i_req_valid && o_req_ready;
    assign cur_bits    = tree[i_set_addr];
    assign victim      = find_victim(cur_bits);
    assign hit_onehot  = $onehot(i_hit_way);

    always_comb begin
        hit_enc = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (i_hit_way[i]) hit_enc = WAY_W'(i);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_bits = cur_bits;
        way_d    = '0;
        err_d    = 1'b0;
        unique case (op_e'(i_req_op))
            OP_HIT, OP_INV: begin
                if (hit_onehot) begin
                    nxt_bits = touch(cur_bits, hit_enc, i_req_op == OP_INV);
                    way_d    = hit_enc;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_MISS: begin
                nxt_bits = touch(cur_bits, victim, 1'b0);
                way_d    = victim;
            end
            OP_CLR: nxt_bits = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tree array is reset because a defined victim (way 0) is
            // required after reset; plain data memories would not be.
            for (int s = 0; s < SETS; s++) tree[s] <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_way   <= '0;
            o_rsp_set   <= '0;
            o_rsp_op    <= '0;
            o_rsp_err   <= 1'b0;
        end else if (accept) begin
            tree[i_set_addr] <= nxt_bits;
            o_rsp_valid      <= 1'b1;
            o_rsp_way        <= way_d;
            o_rsp_set        <= i_set_addr;
            o_rsp_op         <= i_req_op;
            o_rsp_err        <= err_d;
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule
